// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction array answering FETCH_WIDTH-word fetches
// after a fixed read latency, through a credit-limited in-order response FIFO.
module imem_responder #(
   parameter int FETCH_WIDTH   = 4,
   parameter int CPU_ADDR_BITS = 32,
   parameter int CPU_INST_BITS = 32,
   parameter int MEM_WORDS     = 1024,
   parameter int READ_LATENCY  = 2,
   parameter int RESP_DEPTH    = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   output logic                                 imem_req_rdy,
   input  logic                                 imem_req_val,
   input  logic [CPU_ADDR_BITS-1:0]             imem_req_packet,
   input  logic                                 imem_rec_rdy,
   output logic                                 imem_rec_val,
   output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] imem_rec_packet,
   input  logic                                 prog_we,
   input  logic [$clog2(MEM_WORDS)-1:0]         prog_addr,
   input  logic [CPU_INST_BITS-1:0]             prog_data
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CW = $clog2(RESP_DEPTH + 1);
   localparam int DW = FETCH_WIDTH * CPU_INST_BITS;

   logic [CPU_INST_BITS-1:0] r_mem [MEM_WORDS];
   logic [DW-1:0]            r_fifo [RESP_DEPTH];
   logic [DW-1:0]            r_hold;
   logic [CW-1:0]            r_outstanding;
   logic [CW-1:0]            r_count;
   logic [PW-1:0]            r_rd_ptr;
   logic [PW-1:0]            r_wr_ptr;

   logic          w_accept;
   logic          w_pop;
   logic          w_push;
   logic [AW-1:0] w_base;
   logic [DW-1:0] w_rd_data;
   logic [DW-1:0] w_push_data;
   logic          w_unused_addr;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign imem_req_rdy    = rst && (r_outstanding < CW'(RESP_DEPTH));
   assign w_accept        = imem_req_val && imem_req_rdy;
   assign imem_rec_val    = (r_count != '0);
   assign w_pop           = imem_rec_val && imem_rec_rdy;
   assign imem_rec_packet = imem_rec_val ? r_fifo[r_rd_ptr] : r_hold;
   assign w_base          = imem_req_packet[AW+1:2];
   assign w_unused_addr   = ^{imem_req_packet[CPU_ADDR_BITS-1:AW+2], imem_req_packet[1:0]};

   // lane reads; the index add wraps naturally because MEM_WORDS is a power of two
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         w_rd_data[i*CPU_INST_BITS +: CPU_INST_BITS] = r_mem[w_base + AW'(i)];
      end
   end

   // program port; array contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (prog_we) begin
         r_mem[prog_addr] <= prog_data;
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_direct
         assign w_push      = w_accept;
         assign w_push_data = w_rd_data;
      end else begin : g_pipe
         logic [READ_LATENCY-2:0] r_pv;
         logic [DW-1:0]           r_pd [READ_LATENCY-1];

         // valid shift chain; reset discards anything in flight
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_pv <= '0;
            end else begin
               r_pv[0] <= w_accept;
               for (int j = 1; j < READ_LATENCY - 1; j++) begin
                  r_pv[j] <= r_pv[j-1];
               end
            end
         end

         // data shift chain travelling alongside the valids
         always_ff @(posedge clk) begin
            r_pd[0] <= w_rd_data;
            for (int j = 1; j < READ_LATENCY - 1; j++) begin
               r_pd[j] <= r_pd[j-1];
            end
         end

         assign w_push      = r_pv[READ_LATENCY-2];
         assign w_push_data = r_pd[READ_LATENCY-2];
      end
   endgenerate

   // credit counter, FIFO occupancy/pointers and the hold register shown when empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_outstanding <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_hold        <= '0;
      end else begin
         case ({w_accept, w_pop})
            2'b10:   r_outstanding <= r_outstanding + CW'(1);
            2'b01:   r_outstanding <= r_outstanding - CW'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_push) begin
            r_wr_ptr <= ptr_next(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_next(r_rd_ptr);
            r_hold   <= r_fifo[r_rd_ptr];
         end
      end
   end

   // FIFO storage; the credit limit guarantees a push never lands on the live head
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= w_push_data;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_imem_responder;
   localparam int FW    = 4;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int WORDS = 1024;

   logic         clk;
   logic         rst;
   logic         imem_req_rdy;
   logic         imem_req_val;
   logic [31:0]  imem_req_packet;
   logic         imem_rec_rdy;
   logic         imem_rec_val;
   logic [127:0] imem_rec_packet;
   logic         prog_we;
   logic [9:0]   prog_addr;
   logic [31:0]  prog_data;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   imem_responder #(
      .FETCH_WIDTH(FW), .CPU_ADDR_BITS(32), .CPU_INST_BITS(32),
      .MEM_WORDS(WORDS), .READ_LATENCY(LAT), .RESP_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req_rdy(imem_req_rdy), .imem_req_val(imem_req_val),
      .imem_req_packet(imem_req_packet),
      .imem_rec_rdy(imem_rec_rdy), .imem_rec_val(imem_rec_val),
      .imem_rec_packet(imem_rec_packet),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [127:0] data;
      int           ready;
   } ent_t;

   logic [31:0]  mm [WORDS];
   ent_t         mq [$];
   logic [127:0] m_last;
   int           mcyc;
   bit           m_pop, m_acc;
   ent_t         m_ent;
   int           m_base;

   function automatic bit model_val();
      return (mq.size() > 0) && (mq[0].ready <= mcyc);
   endfunction

   function automatic logic [127:0] model_pkt();
      if (model_val()) return mq[0].data;
      return m_last;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_last = '0;
         mcyc   = 0;
      end else begin
         m_pop = model_val() && imem_rec_rdy;
         m_acc = imem_req_val && (mq.size() < DEPTH);
         if (m_acc) begin
            m_base = int'(imem_req_packet >> 2) % WORDS;
            for (int i = 0; i < FW; i++) begin
               m_ent.data[i*32 +: 32] = mm[(m_base + i) % WORDS];
            end
            m_ent.ready = mcyc + LAT;
         end
         if (m_pop) begin
            m_last = mq[0].data;
            void'(mq.pop_front());
         end
         if (m_acc) mq.push_back(m_ent);
         if (prog_we) mm[prog_addr] = prog_data;
         mcyc = mcyc + 1;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_rdy",    128'(imem_req_rdy), 128'(rst && (mq.size() < DEPTH)));
         chk("rec_val",    128'(imem_rec_val), 128'(model_val()));
         chk("rec_packet", imem_rec_packet, model_pkt());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input string name, output logic [127:0] pkt);
      int n;
      n = 0;
      @(negedge clk);
      while (!imem_rec_val && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, 128'(imem_rec_val), 128'(1));
      pkt = imem_rec_packet;
   endtask

   task automatic fill_and_count(input logic [31:0] base_addr, output int n_acc);
      logic acc;
      n_acc           = 0;
      imem_rec_rdy    = 1'b0;
      imem_req_val    = 1'b1;
      imem_req_packet = base_addr;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         acc = imem_req_rdy;
         @(posedge clk);
         #1;
         if (acc) begin
            n_acc++;
            imem_req_packet = base_addr + 32'(16 * n_acc);
         end
      end
      imem_req_val = 1'b0;
   endtask

   // ---------------- directed + random scenarios ----------------
   logic [127:0] pkt, exp;
   logic [31:0]  lane0s [$];
   int           first, last, n_acc;

   initial begin
      rst = 1'b1; imem_req_val = 1'b0; imem_req_packet = 32'h0; imem_rec_rdy = 1'b0;
      prog_we = 1'b0; prog_addr = 10'h0; prog_data = 32'h0;
      #2 rst = 1'b0;
      #1 chk_en = 1'b1;
      tick();
      rst = 1'b1;

      for (int k = 0; k < WORDS; k++) begin
         prog_we = 1'b1; prog_addr = 10'(k); prog_data = 32'h1000 + 32'(k);
         tick();
      end
      prog_we = 1'b0;

      rst = 1'b0;
      @(negedge clk); chk("rdy_during_reset", 128'(imem_req_rdy), 128'(0));
      tick();
      rst = 1'b1;
      @(negedge clk); chk("rdy_after_reset", 128'(imem_req_rdy), 128'(1));
      tick();

      // single fetch: two-cycle latency, one-cycle valid
      imem_rec_rdy = 1'b1; imem_req_val = 1'b1; imem_req_packet = 32'h10;
      tick();
      imem_req_val = 1'b0;
      @(negedge clk); chk("single_early", 128'(imem_rec_val), 128'(0));
      @(negedge clk);
      exp = {32'h1007, 32'h1006, 32'h1005, 32'h1004};
      chk("single_val", 128'(imem_rec_val), 128'(1));
      chk("single_lanes", imem_rec_packet, exp);
      chk("model_pin_single", model_pkt(), exp);
      @(negedge clk); chk("single_one_cycle", 128'(imem_rec_val), 128'(0));
      tick();

      // streaming
      first = -1; last = -1; lane0s.delete();
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               imem_req_val = 1'b1; imem_req_packet = 32'(i * 16);
               @(negedge clk); chk("stream_rdy", 128'(imem_req_rdy), 128'(1));
               @(posedge clk); #1;
            end
            imem_req_val = 1'b0;
         end
         begin
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               if (imem_rec_val) begin
                  if (first < 0) first = c;
                  last = c;
                  lane0s.push_back(imem_rec_packet[31:0]);
               end
            end
         end
      join
      chk("stream_count", 128'(lane0s.size()), 128'(5));
      chk("stream_no_bubble", 128'(last - first), 128'(4));
      for (int i = 0; i < lane0s.size(); i++)
         chk("stream_order", 128'(lane0s[i]), 128'(32'h1000 + 32'(4 * i)));
      tick();

      // backpressure and full
      fill_and_count(32'h100, n_acc);
      chk("full_accepts", 128'(n_acc), 128'(4));
      @(negedge clk);
      chk("full_rdy", 128'(imem_req_rdy), 128'(0));
      chk("full_head", imem_rec_packet, {32'h1043, 32'h1042, 32'h1041, 32'h1040});
      tick();
      imem_rec_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("drain_val", 128'(imem_rec_val), 128'(1));
         chk("drain_order", 128'(imem_rec_packet[31:0]), 128'(32'h1040 + 32'(4 * i)));
         chk("drain_rdy", 128'(imem_req_rdy), 128'(i == 0 ? 0 : 1));
      end
      @(negedge clk); chk("drain_empty", 128'(imem_rec_val), 128'(0));
      tick();

      // wrap-around and misalignment
      imem_req_val = 1'b1; imem_req_packet = 32'hFF6;
      tick();
      imem_req_val = 1'b0;
      wait_resp("wrap_timeout", pkt);
      exp = {32'h1000, 32'h13FF, 32'h13FE, 32'h13FD};
      chk("wrap_lanes", pkt, exp);
      tick();

      // program-port ordering
      imem_req_val = 1'b1; imem_req_packet = 32'h20;
      prog_we = 1'b1; prog_addr = 10'd8; prog_data = 32'hDEADBEEF;
      tick();
      prog_we = 1'b0;
      tick();
      imem_req_val = 1'b0;
      wait_resp("prog_old_timeout", pkt);
      chk("prog_old", 128'(pkt[31:0]), 128'(32'h1008));
      wait_resp("prog_new_timeout", pkt);
      chk("prog_new", 128'(pkt[31:0]), 128'(32'hDEADBEEF));
      tick();

      // reset mid-operation
      imem_rec_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         imem_req_val = 1'b1; imem_req_packet = 32'h200 + 32'(16 * i);
         tick();
      end
      imem_req_val = 1'b0;
      tick(); tick();
      chk("pre_reset_val", 128'(imem_rec_val), 128'(1));
      rst = 1'b0;
      #1;
      chk("reset_val_drop", 128'(imem_rec_val), 128'(0));
      chk("reset_rdy_drop", 128'(imem_req_rdy), 128'(0));
      tick();
      rst = 1'b1; imem_rec_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); chk("no_stale", 128'(imem_rec_val), 128'(0));
      end
      tick();
      fill_and_count(32'h300, n_acc);
      chk("post_reset_accepts", 128'(n_acc), 128'(4));
      imem_rec_rdy = 1'b1;
      for (int i = 0; i < 8; i++) tick();

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst = 1'b0; prog_we = 1'b0; imem_req_val = 1'b0;
            tick();
            if ($urandom_range(0, 1) == 1) tick();
            rst = 1'b1;
         end
         imem_req_val    = ($urandom_range(0, 9) < 6);
         imem_req_packet = $urandom;
         imem_rec_rdy    = (c < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) < 8);
         prog_we         = ($urandom_range(0, 9) == 0);
         prog_addr       = 10'($urandom_range(0, WORDS - 1));
         prog_data       = $urandom;
         tick();
      end
      imem_req_val = 1'b0; prog_we = 1'b0; imem_rec_rdy = 1'b1;
      for (int i = 0; i < 10; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
